// File: rtl/e_alu_mdu_pkg.sv
// Shared op encodings, exception codes and op-class predicates for the E-stage ALU/MDU.
package e_alu_mdu_pkg;

    localparam int unsigned OP_W  = 5;
    localparam int unsigned EXC_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADDU   = 5'd0,
        OP_ADD    = 5'd1,
        OP_SUB    = 5'd2,
        OP_OR     = 5'd3,
        OP_AND    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SLTU   = 5'd6,
        OP_LUI    = 5'd7,
        OP_ADD_LW = 5'd8,
        OP_ADD_LH = 5'd9,
        OP_ADD_LB = 5'd10,
        OP_ADD_SW = 5'd11,
        OP_ADD_SH = 5'd12,
        OP_ADD_SB = 5'd13,
        OP_MULT   = 5'd14,
        OP_MULTU  = 5'd15,
        OP_DIV    = 5'd16,
        OP_DIVU   = 5'd17,
        OP_MTHI   = 5'd18,
        OP_MTLO   = 5'd19,
        OP_MFHI   = 5'd20,
        OP_MFLO   = 5'd21
    } op_e;

    typedef enum logic [EXC_W-1:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_OV   = 5'd12
    } exc_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Ops that launch a multi-cycle multiply/divide.
    function automatic logic is_mdu_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_load_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD_LW) || (op == OP_ADD_LH) || (op == OP_ADD_LB);
    endfunction

    function automatic logic is_store_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD_SW) || (op == OP_ADD_SH) || (op == OP_ADD_SB);
    endfunction

endpackage

// File: rtl/e_mdu_core.sv
// Multiply/divide unit: captures operands at start, counts busy cycles, commits HI/LO at the end.
module e_mdu_core
    import e_alu_mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [OP_W-1:0]   op,
    input  logic              valid,
    output logic              busy,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   pend_q, pend_d;
    logic                 pend_we_q, pend_we_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [2*WIDTH-1:0]   prod_s, prod_u;
    logic                 b_zero, div_ovf;
    logic [WIDTH-1:0]     sdiv_b, udiv_b;
    logic [WIDTH-1:0]     squot, srem, uquot, urem;

    // Full-width results of the current operands; MIN/-1 divides by 1 to yield LO=MIN, HI=0.
    always_comb begin
        prod_s  = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
        prod_u  = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        b_zero  = ~|op_b;
        div_ovf = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
        sdiv_b  = (b_zero || div_ovf) ? WIDTH'(1) : op_b;
        udiv_b  = b_zero ? WIDTH'(1) : op_b;
        squot   = WIDTH'($signed(op_a) / $signed(sdiv_b));
        srem    = WIDTH'($signed(op_a) % $signed(sdiv_b));
        uquot   = op_a / udiv_b;
        urem    = op_a % udiv_b;
    end

    // Busy FSM next state, start capture, MT writes and commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (valid) begin
                    case (op)
                        OP_MULT: begin
                            pend_d    = prod_s;
                            pend_we_d = 1'b1;
                            cnt_d     = CNT_W'(MUL_CYCLES - 1);
                            state_d   = MDU_BUSY;
                        end
                        OP_MULTU: begin
                            pend_d    = prod_u;
                            pend_we_d = 1'b1;
                            cnt_d     = CNT_W'(MUL_CYCLES - 1);
                            state_d   = MDU_BUSY;
                        end
                        OP_DIV: begin
                            pend_d    = {srem, squot};
                            pend_we_d = ~b_zero;
                            cnt_d     = CNT_W'(DIV_CYCLES - 1);
                            state_d   = MDU_BUSY;
                        end
                        OP_DIVU: begin
                            pend_d    = {urem, uquot};
                            pend_we_d = ~b_zero;
                            cnt_d     = CNT_W'(DIV_CYCLES - 1);
                            state_d   = MDU_BUSY;
                        end
                        OP_MTHI: hi_d = op_a;
                        OP_MTLO: lo_d = op_a;
                        default: ;
                    endcase
                end
            end
            MDU_BUSY: begin
                if (cnt_q == '0) begin
                    if (pend_we_q) begin
                        hi_d = pend_q[2*WIDTH-1:WIDTH];
                        lo_d = pend_q[WIDTH-1:0];
                    end
                    state_d = MDU_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // State and HI/LO registers; reset aborts any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_we_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q == MDU_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/e_alu_mdu.sv
// E-stage arithmetic: single-cycle ALU with Ov/AdEL/AdES detection plus multi-cycle MDU.
module e_alu_mdu
    import e_alu_mdu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  E_A,
    input  logic [WIDTH-1:0]  E_B,
    input  logic [OP_W-1:0]   E_Op,
    input  logic              E_Start,
    input  logic              E_Flush,
    output logic [WIDTH-1:0]  E_Result,
    output logic [EXC_W-1:0]  E_ExcCode,
    output logic              E_Busy,
    output logic              E_Stall
);

    logic [WIDTH:0]     sum_x, dif_x;
    logic               ov_add, ov_sub, slt, addr_fault;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   result_c;
    exc_e               exc_c;

    e_mdu_core #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu (
        .clk   (clk),
        .rst_n (reset),
        .op_a  (E_A),
        .op_b  (E_B),
        .op    (E_Op),
        .valid (E_Start & ~E_Flush),
        .busy  (E_Busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Sign-extended sum/difference expose signed overflow in the top two bits.
    always_comb begin
        sum_x      = {E_A[WIDTH-1], E_A} + {E_B[WIDTH-1], E_B};
        dif_x      = {E_A[WIDTH-1], E_A} - {E_B[WIDTH-1], E_B};
        ov_add     = sum_x[WIDTH] ^ sum_x[WIDTH-1];
        ov_sub     = dif_x[WIDTH] ^ dif_x[WIDTH-1];
        slt        = $signed(E_A) < $signed(E_B);
        addr_fault = ov_add
                   | (((E_Op == OP_ADD_LW) || (E_Op == OP_ADD_SW)) && (sum_x[1:0] != 2'b00))
                   | (((E_Op == OP_ADD_LH) || (E_Op == OP_ADD_SH)) && sum_x[0]);
    end

    // Result mux; MDU launch and MT ops produce no result.
    always_comb begin
        result_c = '0;
        case (E_Op)
            OP_ADDU, OP_ADD,
            OP_ADD_LW, OP_ADD_LH, OP_ADD_LB,
            OP_ADD_SW, OP_ADD_SH, OP_ADD_SB: result_c = sum_x[WIDTH-1:0];
            OP_SUB:  result_c = dif_x[WIDTH-1:0];
            OP_OR:   result_c = E_A | E_B;
            OP_AND:  result_c = E_A & E_B;
            OP_SLT:  result_c = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: result_c = {{(WIDTH-1){1'b0}}, (E_A < E_B)};
            OP_LUI:  result_c = E_B << 16;
            OP_MFHI: result_c = hi;
            OP_MFLO: result_c = lo;
            default: result_c = '0;
        endcase
    end

    // Exception priority: AdES over AdEL over Ov.
    always_comb begin
        exc_c = EXC_NONE;
        if (is_store_op(E_Op) && addr_fault) begin
            exc_c = EXC_ADES;
        end else if (is_load_op(E_Op) && addr_fault) begin
            exc_c = EXC_ADEL;
        end else if (((E_Op == OP_ADD) && ov_add) || ((E_Op == OP_SUB) && ov_sub)) begin
            exc_c = EXC_OV;
        end
    end

    assign E_Result  = result_c;
    assign E_ExcCode = exc_c;
    assign E_Stall   = E_Busy | (E_Start & is_mdu_op(E_Op));

endmodule

// File: tb/tb_e_alu_mdu.sv
// Directed plus randomized bench for e_alu_mdu against a cycle-level behavioural model.
module tb_e_alu_mdu;
    import e_alu_mdu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        rst_n;
    logic [31:0] E_A, E_B;
    logic [4:0]  E_Op;
    logic        E_Start, E_Flush;
    logic [31:0] E_Result;
    logic [4:0]  E_ExcCode;
    logic        E_Busy, E_Stall;

    int total  = 0;
    int passes = 0;

    // Behavioural model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;
    bit          m_we;

    logic [31:0] last_res;
    logic [4:0]  last_exc;
    logic        last_busy, last_stall;

    e_alu_mdu #(.WIDTH(32), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .E_A       (E_A),
        .E_B       (E_B),
        .E_Op      (E_Op),
        .E_Start   (E_Start),
        .E_Flush   (E_Flush),
        .E_Result  (E_Result),
        .E_ExcCode (E_ExcCode),
        .E_Busy    (E_Busy),
        .E_Stall   (E_Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit is_mdu(input logic [4:0] op);
        return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
    endfunction

    // Expected combinational outputs computed with 64-bit integer arithmetic.
    function automatic void alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [4:0] e);
        longint maxs = (64'sd1 <<< 31) - 1;
        longint mins = -(64'sd1 <<< 31);
        longint sa   = $signed(a);
        longint sb   = $signed(b);
        longint s    = sa + sb;
        longint d    = sa - sb;
        bit ovs      = (s > maxs) || (s < mins);
        bit ovd      = (d > maxs) || (d < mins);
        logic [31:0] addr = a + b;
        bit bad = ovs || ((op == OP_ADD_LW || op == OP_ADD_SW) && addr[1:0] != 2'b00)
                      || ((op == OP_ADD_LH || op == OP_ADD_SH) && addr[0]);
        r = 32'h0;
        case (op)
            OP_ADDU, OP_ADD, OP_ADD_LW, OP_ADD_LH, OP_ADD_LB,
            OP_ADD_SW, OP_ADD_SH, OP_ADD_SB: r = addr;
            OP_SUB:  r = a - b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_LUI:  r = {b[15:0], 16'h0};
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            default: r = 32'h0;
        endcase
        e = 5'd0;
        if ((op == OP_ADD_SW || op == OP_ADD_SH || op == OP_ADD_SB) && bad) e = 5'd5;
        else if ((op == OP_ADD_LW || op == OP_ADD_LH || op == OP_ADD_LB) && bad) e = 5'd4;
        else if ((op == OP_ADD && ovs) || (op == OP_SUB && ovd)) e = 5'd12;
    endfunction

    // Model update for one rising edge.
    task automatic model_edge(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic st, input logic fl);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint p, q, rm;
        logic [63:0] pu;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_we) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st && !fl) begin
            case (op)
                OP_MULT: begin
                    p = sa * sb; pu = p;
                    m_phi = pu[63:32]; m_plo = pu[31:0]; m_we = 1; m_left = MUL_N;
                end
                OP_MULTU: begin
                    pu = {32'h0, a} * {32'h0, b};
                    m_phi = pu[63:32]; m_plo = pu[31:0]; m_we = 1; m_left = MUL_N;
                end
                OP_DIV: begin
                    m_we = (b != 0); m_left = DIV_N;
                    if (b != 0) begin
                        q = sa / sb; rm = sa % sb;
                        m_plo = q[31:0]; m_phi = rm[31:0];
                    end
                end
                OP_DIVU: begin
                    m_we = (b != 0); m_left = DIV_N;
                    if (b != 0) begin
                        m_plo = a / b; m_phi = a % b;
                    end
                end
                OP_MTHI: m_hi = a;
                OP_MTLO: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_we = 0;
    endtask

    // One cycle: drive at negedge, check combinational outputs, clock, update model.
    task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic st, input logic fl);
        logic [31:0] er;
        logic [4:0]  ee;
        logic        es;
        E_Op = op; E_A = a; E_B = b; E_Start = st; E_Flush = fl;
        #1;
        alu_ref(op, a, b, er, ee);
        es = (m_left > 0) || (st && is_mdu(op));
        last_res = E_Result; last_exc = E_ExcCode; last_busy = E_Busy; last_stall = E_Stall;
        check($sformatf("result op%0d a%0h b%0h", op, a, b), 64'(E_Result), 64'(er));
        check($sformatf("exc op%0d a%0h b%0h", op, a, b), 64'(E_ExcCode), 64'(ee));
        check($sformatf("busy op%0d", op), 64'(E_Busy), 64'(m_left > 0));
        check($sformatf("stall op%0d", op), 64'(E_Stall), 64'(es));
        @(posedge clk);
        #1;
        model_edge(op, a, b, st, fl);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hffff_ffff;
            3: return 32'h8000_0000;
            4: return 32'h7fff_ffff;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        model_reset();
        rst_n = 1'b0;
        E_Op = OP_MFHI; E_A = 0; E_B = 0; E_Start = 0; E_Flush = 0;
        #1;
        check("reset_busy", 64'(E_Busy), 64'd0);
        check("reset_hi", 64'(E_Result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU overflow
        step(OP_ADD, 32'h7fff_ffff, 32'h1, 1, 0);
        check("t1_add_res", 64'(last_res), 64'h8000_0000);
        check("t1_add_exc", 64'(last_exc), 64'd12);
        step(OP_ADDU, 32'h7fff_ffff, 32'h1, 1, 0);
        check("t1_addu_exc", 64'(last_exc), 64'd0);

        // Address alignment
        step(OP_ADD_LW, 32'h1001, 32'h2, 1, 0);
        check("t2_lw_exc", 64'(last_exc), 64'd4);
        step(OP_ADD_SH, 32'h2000, 32'h1, 1, 0);
        check("t2_sh_exc", 64'(last_exc), 64'd5);
        step(OP_ADD_SB, 32'h2001, 32'h0, 1, 0);
        check("t2_sb_exc", 64'(last_exc), 64'd0);

        // MULT latency and result
        step(OP_MULT, 32'hffff_ffff, 32'h2, 1, 0);
        check("t3_stall_t", 64'(last_stall), 64'd1);
        check("t3_busy_t", 64'(last_busy), 64'd0);
        for (int i = 0; i < MUL_N; i++) begin
            step(OP_ADDU, 32'h0, 32'h0, 0, 0);
            check($sformatf("t3_busy_%0d", i + 1), 64'(last_busy), 64'd1);
        end
        step(OP_MFHI, 32'h0, 32'h0, 1, 0);
        check("t3_busy_done", 64'(last_busy), 64'd0);
        check("t3_hi", 64'(last_res), 64'hffff_ffff);
        step(OP_MFLO, 32'h0, 32'h0, 1, 0);
        check("t3_lo", 64'(last_res), 64'hffff_fffe);

        // Signed divide, then divide by zero
        step(OP_DIV, 32'hffff_fff9, 32'h2, 1, 0);
        for (int i = 0; i < DIV_N; i++) begin
            step(OP_ADDU, 32'h0, 32'h0, 0, 0);
            check($sformatf("t4_div_busy_%0d", i + 1), 64'(last_busy), 64'd1);
        end
        step(OP_MFLO, 32'h0, 32'h0, 1, 0);
        check("t4_div_lo", 64'(last_res), 64'hffff_fffd);
        step(OP_MFHI, 32'h0, 32'h0, 1, 0);
        check("t4_div_hi", 64'(last_res), 64'hffff_ffff);
        step(OP_DIVU, 32'h7, 32'h0, 1, 0);
        for (int i = 0; i < DIV_N; i++) begin
            step(OP_ADDU, 32'h0, 32'h0, 0, 0);
            check($sformatf("t4_divu0_busy_%0d", i + 1), 64'(last_busy), 64'd1);
        end
        step(OP_MFHI, 32'h0, 32'h0, 1, 0);
        check("t4_divu0_busy_done", 64'(last_busy), 64'd0);
        check("t4_divu0_hi", 64'(last_res), 64'hffff_ffff);
        step(OP_MFLO, 32'h0, 32'h0, 1, 0);
        check("t4_divu0_lo", 64'(last_res), 64'hffff_fffd);

        // Flushed start and MTLO
        step(OP_MULT, 32'h5, 32'h6, 1, 1);
        step(OP_MFHI, 32'h0, 32'h0, 1, 0);
        check("t5_flush_busy", 64'(last_busy), 64'd0);
        check("t5_flush_hi", 64'(last_res), 64'hffff_ffff);
        step(OP_MTLO, 32'h1234, 32'h0, 1, 0);
        step(OP_MFLO, 32'h0, 32'h0, 1, 0);
        check("t5_mtlo", 64'(last_res), 64'h1234);

        // Async reset during DIV
        step(OP_DIV, 32'h100, 32'h7, 1, 0);
        step(OP_ADDU, 32'h0, 32'h0, 0, 0);
        step(OP_ADDU, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 64'(E_Busy), 64'd0);
        E_Op = OP_MFHI;
        #1;
        check("t6_rst_hi", 64'(E_Result), 64'd0);
        E_Op = OP_MFLO;
        #1;
        check("t6_rst_lo", 64'(E_Result), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(OP_MULTU, 32'h3, 32'h4, 1, 0);
        for (int i = 0; i < MUL_N; i++) step(OP_ADDU, 32'h0, 32'h0, 0, 0);
        step(OP_MFLO, 32'h0, 32'h0, 1, 0);
        check("t6_multu_lo", 64'(last_res), 64'd12);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(5'($urandom_range(0, 23)), rnd_val(), rnd_val(),
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
